vscale_ring_linebuf: RTL and testbench
======================================

# vscale_ring_linebuf

Parametrised vertical scaling stage for the SDRAM-to-LCD path, sitting between the SDRAM line reader and the output FIFO / horizontal scaler. Source lines are stored in a ring of NBUF line buffers. For each target line the block steps a fixed-point source-line position and reads the two bracketing source lines in parallel. It then emits bilinear-interpolated (or nearest-neighbour) pixels for CH channels under a valid/ready handshake. It generalises the ping-pong buffer / vertical scaler / interpolator chain to N buffers, any channel count and pixel width, downscaling with automatic line skipping, and output backpressure.

## Interface
- PIX_W, 8, bits per channel
- CH, 2, channels per pixel (e.g. Y and C)
- NBUF, 4, line buffers in the ring; power of two, ≥ 3
- LINE_AW, 10, buffer address width; maximum line length is 2^LINE_AW pixels
- FRAC, 8, fractional bits of cfg_step and of the position accumulator
- clk_108m  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse that discards all stored lines and restarts the frame
- cfg_width  in  LINE_AW+1  pixels per line, 1..2^LINE_AW
- cfg_src_lines  in  12  source lines per frame, ≥ 1
- cfg_tgt_lines  in  12  target lines per frame, ≥ 1
- cfg_step  in  12+FRAC  source lines advanced per target line (unsigned fixed point)
- cfg_mode  in  1  0 = bilinear, 1 = nearest
- wr_valid / wr_ready  in / out  1  source pixel handshake
- wr_data  in  CH*PIX_W  source pixel; channel 0 in the MSBs
- out_valid / out_ready  out / in  1  target pixel handshake
- out_data  out  CH*PIX_W  target pixel
- out_line_end  out  1  qualifies the last pixel of a target line
- out_frame_end  out  1  qualifies the last pixel of the frame
- lines_filled  out  $clog2(NBUF)+1  ring occupancy

## Operation
- Configuration inputs are static from frame_start until out_frame_end.
- **Writer**
  - wr_ready = (lines_filled < NBUF) && (src_wr_line < cfg_src_lines).
  - A transfer writes buffer wp at address col, then increments col.
  - At col == cfg_width-1, col wraps to 0, wp advances modulo NBUF, src_wr_line increments and lines_filled increments.
- **Reader**
  - Registers: pos (12+FRAC bits), tgt_line, base_line (source line held in buffer rb).
  - ip = min(pos>>FRAC, cfg_src_lines-1); k = pos[FRAC-1:0]; hi = min(ip+1, cfg_src_lines-1).
- **FSM states**
  - IDLE: one cycle; computes ip, k and hi.
  - RELEASE: while base_line < ip and lines_filled > 0, frees one buffer per cycle (base_line++, rb++, lines_filled--). Moves to WAIT once base_line == ip.
  - WAIT: holds until src_wr_line > hi.
  - RUN: issues column addresses 0..cfg_width-1, one per enabled cycle, reading buffers rb (line A) and rb+(hi-ip) (line B).
  - At the end of RUN: tgt_line++ and pos += cfg_step. The FSM goes to IDLE, or to DONE if tgt_line == cfg_tgt_lines.
  - DONE: holds until frame_start.
- **Interpolation**, per channel:
  - Bilinear: out = (A·(2^FRAC−k) + B·k + 2^(FRAC−1)) >> FRAC. The intermediate is PIX_W+FRAC+1 bits; the result never exceeds 2^PIX_W−1 and is not saturated.
  - Nearest: out = (k ≥ 2^(FRAC−1)) ? B : A.
  - When hi == ip (last source line), A and B read the same line and out = A.
- **Simultaneous writer release/fill**: if a writer line completion and a reader release land in the same cycle, lines_filled stays unchanged.
- **frame_start**
  - Wins over everything else; a wr_valid in the same cycle is dropped.
  - The next cycle has all counters cleared, the FSM in IDLE, and the pipeline flushed (out_valid = 0).

## Timing
- **Reset values:** out_valid = 0, out_line_end = 0, out_frame_end = 0, out_data = 0, lines_filled = 0, FSM = IDLE. wr_ready is combinational from registers, so it is 1 right after reset whenever cfg_src_lines ≠ 0.
- **Write path:** pixel written in the same cycle as the handshake. lines_filled and src_wr_line update on the edge following the last-pixel transfer.
- **Read pipeline:** address (stage 0), RAM data (stage 1), registered interpolation result (stage 2).
  - A RUN address issued in cycle c yields out_valid in cycle c+2.
  - Pipeline enable = !out_valid || out_ready; when it is low, the address, RAM read enable and stage registers all hold.
  - out_data is stable while out_valid && !out_ready.
- **Throughput:** one pixel per cycle during RUN with out_ready held high.
- **Per-line overhead:** 1 IDLE cycle, plus (ip − previous ip) RELEASE cycles, plus WAIT time.
- **Line/frame flags:** out_line_end and out_frame_end travel with the pixel through the pipeline.
- **Deadlock freedom:** NBUF ≥ 3 guarantees the writer can fill line hi while line ip is held.

## Test plan
- **1:1 copy:** cfg_width=4, src=tgt=3, step=1.0 (0x100), bilinear, out_ready=1; source line n pixels = 16n+col → output identical, 12 pixels, out_line_end on pixels 3/7/11, out_frame_end on pixel 11 only.
- **2× upscale:** step=0x080, src=2, tgt=4, line0=0x00, line1=0x80 → lines 0x00, 0x40, 0x80, 0x80. Nearest mode → 0x00, 0x80, 0x80, 0x80.
- **2× downscale:** step=0x200, src=8, tgt=4 → outputs are source lines 0, 2, 4, 6; RELEASE frees 2 buffers per line; lines_filled never exceeds 4; wr_ready drops while the ring is full.
- **Backpressure:** toggle out_ready 1/0 every cycle during RUN → no pixel lost or duplicated; out_data constant while stalled; same sequence as the 1:1 copy test.
- **frame_start mid-line:** assert frame_start during RUN with lines_filled=3 → next cycle out_valid=0 and lines_filled=0. The new frame reproduces the 1:1 copy test output exactly.
- **Reset:** assert rst during RUN → all outputs at their reset values immediately; after release, the block behaves as after frame_start.

Source files
------------

// File: rtl/vscale_ring_linebuf_if.sv
// Pixel streams of the vertical scaler.
//   wr_*  : source pixels from the SDRAM line reader (valid/ready)
//   out_* : interpolated target pixels towards the output FIFO (valid/ready),
//           with line/frame end qualifiers travelling alongside the pixel.
// slave  = scaler side, master = line reader / sink side.
interface vscale_ring_linebuf_if #(
  parameter int PIX_W = 8,
  parameter int CH    = 2
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [CH*PIX_W-1:0]   wr_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*PIX_W-1:0]   out_data;
  logic                  out_line_end;
  logic                  out_frame_end;

  modport slave (
    input  wr_valid, wr_data, out_ready,
    output wr_ready, out_valid, out_data, out_line_end, out_frame_end
  );

  modport master (
    output wr_valid, wr_data, out_ready,
    input  wr_ready, out_valid, out_data, out_line_end, out_frame_end
  );
endinterface

// File: rtl/vscale_ring_linebuf.sv
// Vertical scaler with a ring of NBUF line buffers.
// Source lines are written round-robin into the ring; for each target line a
// fixed-point source position selects the two bracketing lines, which are read
// in parallel and blended per channel (bilinear or nearest).
// Ports:
//   clk_108m, rst (async, active-high), frame_start (restart pulse)
//   cfg_width/src_lines/tgt_lines/step/mode : per-frame static configuration
//   bus (slave)  : source pixel input and target pixel output streams
//   lines_filled : number of complete source lines held in the ring
module vscale_ring_linebuf #(
  parameter int PIX_W   = 8,
  parameter int CH      = 2,
  parameter int NBUF    = 4,
  parameter int LINE_AW = 10,
  parameter int FRAC    = 8
) (
  input  logic                    clk_108m,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [LINE_AW:0]        cfg_width,
  input  logic [11:0]             cfg_src_lines,
  input  logic [11:0]             cfg_tgt_lines,
  input  logic [11+FRAC:0]        cfg_step,
  input  logic                    cfg_mode,
  vscale_ring_linebuf_if.slave    bus,
  output logic [$clog2(NBUF):0]   lines_filled
);
  localparam int DW    = CH*PIX_W;
  localparam int BW    = $clog2(NBUF);
  localparam int DEPTH = 1 << LINE_AW;
  localparam int MW    = PIX_W + FRAC + 1;

  typedef enum logic [2:0] {S_IDLE, S_RELEASE, S_WAIT, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]       mem_q [NBUF*DEPTH];
  logic [LINE_AW-1:0]  col_q, rcol_q;
  logic [BW-1:0]       wp_q, rb_q, rb_b;
  logic [BW:0]         lines_filled_q;
  logic [11:0]         src_wr_q, tgt_q, base_q, ip_q, hi_q;
  logic [11+FRAC:0]    pos_q;
  logic [FRAC-1:0]     k_q, k_p1_q;
  logic                vld_p1_q, le_p1_q, fe_p1_q;
  logic [DW-1:0]       a_p1_q, b_p1_q;
  logic                vld_p2_q, le_p2_q, fe_p2_q;
  logic [DW-1:0]       data_p2_q, interp_c;

  logic        en, wr_fire, wr_last, rel, run_fire, run_last, last_tgt;
  logic [11:0] pos_int, last_line, ip_c, hi_c;
  logic [12:0] ip_inc;

  // Rounded bilinear blend, or nearest pick on the upper half of k.
  // a*(2^FRAC-k)+b*k never exceeds (2^PIX_W-1)*2^FRAC, so no saturation.
  function automatic logic [PIX_W-1:0] interp(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [FRAC-1:0]  k,
                                              input logic             nearest);
    logic [FRAC:0]  ka;
    logic [MW-1:0]  acc;
    ka  = (FRAC+1)'(1 << FRAC) - {1'b0, k};
    acc = MW'(a) * MW'(ka) + MW'(b) * MW'(k) + MW'(1 << (FRAC-1));
    if (nearest) interp = k[FRAC-1] ? b : a;
    else         interp = acc[FRAC +: PIX_W];
  endfunction

  assign en            = !vld_p2_q || bus.out_ready;
  assign bus.wr_ready  = (lines_filled_q < (BW+1)'(NBUF)) && (src_wr_q < cfg_src_lines);
  assign wr_fire       = bus.wr_valid && bus.wr_ready && !frame_start;
  assign wr_last       = ({1'b0, col_q} == cfg_width - 1'b1);
  assign run_last      = ({1'b0, rcol_q} == cfg_width - 1'b1);
  assign last_tgt      = (tgt_q + 12'd1 == cfg_tgt_lines);
  assign lines_filled  = lines_filled_q;

  assign pos_int   = pos_q[FRAC +: 12];
  assign last_line = cfg_src_lines - 12'd1;
  assign ip_c      = (pos_int > last_line) ? last_line : pos_int;
  assign ip_inc    = {1'b0, ip_c} + 13'd1;
  assign hi_c      = (ip_inc > {1'b0, last_line}) ? last_line : ip_inc[11:0];
  // Line B is the next ring slot unless the position is clamped to the last line.
  assign rb_b      = rb_q + {{(BW-1){1'b0}}, (hi_q != ip_q)};

  always_comb begin
    state_d  = state_q;
    rel      = 1'b0;
    run_fire = 1'b0;
    case (state_q)
      S_IDLE:    state_d = (base_q == ip_c) ? S_WAIT : S_RELEASE;
      S_RELEASE: if (lines_filled_q != '0) begin
                   rel = 1'b1;
                   if (base_q + 12'd1 == ip_q) state_d = S_WAIT;
                 end
      S_WAIT:    if (src_wr_q > hi_q) state_d = S_RUN;
      S_RUN:     if (en) begin
                   run_fire = 1'b1;
                   if (run_last) state_d = last_tgt ? S_DONE : S_IDLE;
                 end
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_108m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  col_q <= '0;  wp_q <= '0;  src_wr_q <= '0;
      lines_filled_q <= '0;  rcol_q <= '0;  rb_q <= '0;  base_q <= '0;
      tgt_q <= '0;  pos_q <= '0;  ip_q <= '0;  hi_q <= '0;  k_q <= '0;
      vld_p1_q <= 1'b0;  le_p1_q <= 1'b0;  fe_p1_q <= 1'b0;  k_p1_q <= '0;
      vld_p2_q <= 1'b0;  le_p2_q <= 1'b0;  fe_p2_q <= 1'b0;  data_p2_q <= '0;
    end else if (frame_start) begin
      state_q <= S_IDLE;  col_q <= '0;  wp_q <= '0;  src_wr_q <= '0;
      lines_filled_q <= '0;  rcol_q <= '0;  rb_q <= '0;  base_q <= '0;
      tgt_q <= '0;  pos_q <= '0;
      vld_p1_q <= 1'b0;  le_p1_q <= 1'b0;  fe_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;  le_p2_q <= 1'b0;  fe_p2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_fire) begin
        col_q <= wr_last ? '0 : col_q + 1'b1;
        if (wr_last) begin
          wp_q     <= wp_q + 1'b1;
          src_wr_q <= src_wr_q + 12'd1;
        end
      end
      // A fill and a release in the same cycle cancel out.
      case ({wr_fire && wr_last, rel})
        2'b10:   lines_filled_q <= lines_filled_q + 1'b1;
        2'b01:   lines_filled_q <= lines_filled_q - 1'b1;
        default: lines_filled_q <= lines_filled_q;
      endcase
      if (state_q == S_IDLE) begin
        ip_q <= ip_c;
        hi_q <= hi_c;
        k_q  <= pos_q[FRAC-1:0];
      end
      if (rel) begin
        base_q <= base_q + 12'd1;
        rb_q   <= rb_q + 1'b1;
      end
      if (state_q == S_WAIT) rcol_q <= '0;
      if (run_fire) begin
        rcol_q <= rcol_q + 1'b1;
        if (run_last) begin
          tgt_q <= tgt_q + 12'd1;
          pos_q <= pos_q + cfg_step;
        end
      end
      // stage 0 -> stage 1: address issued, RAM data lands in a_p1/b_p1
      if (en) begin
        vld_p1_q <= run_fire;
        le_p1_q  <= run_fire && run_last;
        fe_p1_q  <= run_fire && run_last && last_tgt;
        k_p1_q   <= k_q;
      end
      // stage 1 -> stage 2: registered interpolation result
      if (en) begin
        vld_p2_q <= vld_p1_q;
        le_p2_q  <= vld_p1_q && le_p1_q;
        fe_p2_q  <= vld_p1_q && fe_p1_q;
        if (vld_p1_q) data_p2_q <= interp_c;
      end
    end
  end

  always_ff @(posedge clk_108m) begin
    if (wr_fire) mem_q[{wp_q, col_q}] <= bus.wr_data;
    if (run_fire) begin
      a_p1_q <= mem_q[{rb_q, rcol_q}];
      b_p1_q <= mem_q[{rb_b, rcol_q}];
    end
  end

  always_comb begin
    interp_c = '0;
    for (int c = 0; c < CH; c++)
      interp_c[c*PIX_W +: PIX_W] = interp(a_p1_q[c*PIX_W +: PIX_W],
                                          b_p1_q[c*PIX_W +: PIX_W], k_p1_q, cfg_mode);
  end

  assign bus.out_valid     = vld_p2_q;
  assign bus.out_data      = data_p2_q;
  assign bus.out_line_end  = le_p2_q;
  assign bus.out_frame_end = fe_p2_q;
endmodule

// File: tb/tb_vscale_ring_linebuf.sv
module tb_vscale_ring_linebuf;
  localparam int PIX_W = 8, CH = 2, NBUF = 4, LINE_AW = 10, FRAC = 8;
  localparam int BUDGET = 3000;

  logic                  clk_108m = 1'b0;
  logic                  rst = 1'b1;
  logic                  frame_start = 1'b0;
  logic [LINE_AW:0]      cfg_width;
  logic [11:0]           cfg_src_lines, cfg_tgt_lines;
  logic [11+FRAC:0]      cfg_step;
  logic                  cfg_mode;
  logic [$clog2(NBUF):0] lines_filled;

  vscale_ring_linebuf_if #(.PIX_W(PIX_W), .CH(CH)) bus ();

  vscale_ring_linebuf #(.PIX_W(PIX_W), .CH(CH), .NBUF(NBUF), .LINE_AW(LINE_AW), .FRAC(FRAC)) dut (
    .clk_108m      (clk_108m),
    .rst           (rst),
    .frame_start   (frame_start),
    .cfg_width     (cfg_width),
    .cfg_src_lines (cfg_src_lines),
    .cfg_tgt_lines (cfg_tgt_lines),
    .cfg_step      (cfg_step),
    .cfg_mode      (cfg_mode),
    .bus           (bus),
    .lines_filled  (lines_filled)
  );

  always #5 clk_108m = ~clk_108m;

  // Source line n, column c: ch0 = s0b + n*s0d + c, ch1 = s1b + n*s1d + c.
  // Target line t, column c: ch0 = t0[8t+:8] + c, ch1 = t1[8t+:8] + c.
  typedef struct packed {
    logic [10:0] width;
    logic [11:0] src;
    logic [11:0] tgt;
    logic [19:0] step;
    logic        mode;
    logic        stall;
    logic [7:0]  pre_hold;
    logic        chk_full;
    logic [7:0]  s0b, s0d, s1b, s1d;
    logic [31:0] t0, t1;
  } vec_t;

  vec_t vt [6];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   saw_full;
  int   max_fill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic load_cfg(input int i);
    cfg_width     = vt[i].width;
    cfg_src_lines = vt[i].src;
    cfg_tgt_lines = vt[i].tgt;
    cfg_step      = vt[i].step;
    cfg_mode      = vt[i].mode;
  endtask

  task automatic pulse_start();
    @(negedge clk_108m) frame_start = 1'b1;
    @(negedge clk_108m) frame_start = 1'b0;
  endtask

  task automatic write_src(input int i);
    int w, total, cnt, cyc, n, c;
    w = int'(vt[i].width);  total = w * int'(vt[i].src);
    cnt = 0;  cyc = 0;
    while (cnt < total && cyc < BUDGET) begin
      @(negedge clk_108m);
      cyc++;
      n = cnt / w;  c = cnt % w;
      bus.wr_valid = 1'b1;
      bus.wr_data  = {vt[i].s0b + 8'(n) * vt[i].s0d + 8'(c),
                      vt[i].s1b + 8'(n) * vt[i].s1d + 8'(c)};
      if (bus.wr_ready) cnt++;
      else saw_full = 1'b1;
    end
    @(negedge clk_108m);
    bus.wr_valid = 1'b0;
    chk($sformatf("v%0d wr_done", i), 32'(cnt), 32'(total));
  endtask

  task automatic read_out(input int i);
    int w, total, got, cyc, t, c;
    bit held;
    logic [15:0] hd;
    logic [7:0]  e0, e1;
    w = int'(vt[i].width);  total = w * int'(vt[i].tgt);
    got = 0;  cyc = 0;  held = 1'b0;  hd = '0;
    while (got < total && cyc < BUDGET) begin
      @(negedge clk_108m);
      cyc++;
      if (int'(lines_filled) > max_fill) max_fill = int'(lines_filled);
      if (held) begin
        chk($sformatf("v%0d hold_valid p%0d", i, got), 32'(bus.out_valid), 32'd1);
        chk($sformatf("v%0d hold_data p%0d", i, got), 32'(bus.out_data), 32'(hd));
      end
      if (cyc <= int'(vt[i].pre_hold)) bus.out_ready = 1'b0;
      else if (vt[i].stall)            bus.out_ready = ~bus.out_ready;
      else                             bus.out_ready = 1'b1;
      held = bus.out_valid && !bus.out_ready;
      hd   = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        t  = got / w;  c = got % w;
        e0 = 8'(vt[i].t0 >> (8*t)) + 8'(c);
        e1 = 8'(vt[i].t1 >> (8*t)) + 8'(c);
        chk($sformatf("v%0d t%0d c%0d data", i, t, c), 32'(bus.out_data), 32'({e0, e1}));
        chk($sformatf("v%0d t%0d c%0d line_end", i, t, c), 32'(bus.out_line_end), 32'(c == w-1));
        chk($sformatf("v%0d t%0d c%0d frame_end", i, t, c), 32'(bus.out_frame_end), 32'(got == total-1));
        got++;
      end
    end
    chk($sformatf("v%0d rd_done", i), 32'(got), 32'(total));
  endtask

  task automatic run_vec(input int i, input bit do_start);
    load_cfg(i);
    if (do_start) pulse_start();
    saw_full = 1'b0;
    max_fill = 0;
    fork
      write_src(i);
      read_out(i);
    join
    chk($sformatf("v%0d ring_le_nbuf", i), 32'(max_fill <= NBUF), 32'd1);
    if (vt[i].chk_full) begin
      chk($sformatf("v%0d ring_max", i), 32'(max_fill), 32'(NBUF));
      chk($sformatf("v%0d wr_ready_low_when_full", i), 32'(saw_full), 32'd1);
    end
  endtask

  initial begin
    //        width  src    tgt    step       mode  stall hold  full  s0b    s0d    s1b    s1d    t0            t1
    vt[0] = '{11'd4, 12'd3, 12'd3, 20'h00100, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h10, 8'h80, 8'h10, 32'h00201000, 32'h00A09080};
    vt[1] = '{11'd2, 12'd2, 12'd4, 20'h00080, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h80, 8'h10, 8'h25, 32'h80804000, 32'h35352310};
    vt[2] = '{11'd2, 12'd2, 12'd4, 20'h00080, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h80, 8'h10, 8'h25, 32'h80808000, 32'h35353510};
    vt[3] = '{11'd2, 12'd2, 12'd3, 20'h000C0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h80, 8'h10, 8'h25, 32'h00806000, 32'h00352C10};
    vt[4] = '{11'd4, 12'd8, 12'd4, 20'h00200, 1'b0, 1'b0, 8'd40, 1'b1, 8'h00, 8'h10, 8'h80, 8'h10, 32'h60402000, 32'hE0C0A080};
    vt[5] = '{11'd4, 12'd3, 12'd3, 20'h00100, 1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 8'h10, 8'h80, 8'h10, 32'h00201000, 32'h00A09080};

    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    load_cfg(0);
    repeat (3) @(negedge clk_108m);
    rst = 1'b0;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_line_end", 32'(bus.out_line_end), 32'd0);
    chk("rst out_frame_end", 32'(bus.out_frame_end), 32'd0);
    chk("rst out_data", 32'(bus.out_data), 32'd0);
    chk("rst lines_filled", 32'(lines_filled), 32'd0);
    chk("rst wr_ready", 32'(bus.wr_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i, 1'b1);

    // frame_start while a line is stalled in RUN with three lines stored
    load_cfg(0);
    pulse_start();
    bus.out_ready = 1'b0;
    write_src(0);
    chk("fs pre lines_filled", 32'(lines_filled), 32'd3);
    chk("fs pre out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk_108m) frame_start = 1'b1;
    @(negedge clk_108m) frame_start = 1'b0;
    chk("fs out_valid", 32'(bus.out_valid), 32'd0);
    chk("fs lines_filled", 32'(lines_filled), 32'd0);
    chk("fs wr_ready", 32'(bus.wr_ready), 32'd1);
    run_vec(0, 1'b0);

    // asynchronous reset while a line is stalled in RUN
    pulse_start();
    bus.out_ready = 1'b0;
    write_src(0);
    chk("rr pre out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr out_valid", 32'(bus.out_valid), 32'd0);
    chk("rr out_line_end", 32'(bus.out_line_end), 32'd0);
    chk("rr out_frame_end", 32'(bus.out_frame_end), 32'd0);
    chk("rr out_data", 32'(bus.out_data), 32'd0);
    chk("rr lines_filled", 32'(lines_filled), 32'd0);
    @(negedge clk_108m) rst = 1'b0;
    run_vec(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
